uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_if.sv | 31 +++
 rtl/uart_rx_fifo.sv | 99 +++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side push signals and host-side pop/status signals of uart_rx_fifo.
interface uart_rx_fifo_if #(parameter int AW = 4);
   logic [7:0]  rx_data_i;
   logic        rx_done_i;
   logic        parity_error_i;
   logic        frame_error_i;
   logic        rd_en;
   logic        fifo_clr;
   logic        ovr_clr;
   logic [1:0]  trig_lvl;
   logic [7:0]  rd_data;
   logic        rd_pe;
   logic        rd_fe;
   logic        empty;
   logic        full;
   logic [AW:0] count;
   logic        overrun;
   logic        trig_int;

   modport master (
      output rx_data_i, rx_done_i, parity_error_i, frame_error_i,
             rd_en, fifo_clr, ovr_clr, trig_lvl,
      input  rd_data, rd_pe, rd_fe, empty, full, count, overrun, trig_int
   );

   modport slave (
      input  rx_data_i, rx_done_i, parity_error_i, frame_error_i,
             rd_en, fifo_clr, ovr_clr, trig_lvl,
      output rd_data, rd_pe, rd_fe, empty, full, count, overrun, trig_int
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO storing {frame_err, parity_err, data} per character.
// Define UART_RX_FIFO_DROP_ERR_EN to discard errored frames instead of storing them.
module uart_rx_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          baud_clk,
   input  logic          reset,
   uart_rx_fifo_if.slave bus
);

   logic [9:0]  mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr, wr_next, rd_next;
   logic [AW:0] count_q, count_next;
   logic        done_q;
   logic        push_req, do_push, do_pop, ovr_set;
   logic [9:0]  entry;
   logic [7:0]  rd_data_q;
   logic        rd_pe_q, rd_fe_q;
   logic        empty_q, full_q, overrun_q;
   int unsigned trig_level;

   always_comb begin
      entry    = {bus.frame_error_i, bus.parity_error_i, bus.rx_data_i};
      push_req = bus.rx_done_i & ~done_q;
`ifdef UART_RX_FIFO_DROP_ERR_EN
      push_req = push_req & ~(bus.parity_error_i | bus.frame_error_i);
`endif
      // A pop frees the slot, so a push into a full FIFO is accepted in the same cycle.
      do_pop   = bus.rd_en & ~empty_q & ~bus.fifo_clr;
      do_push  = push_req & (~full_q | do_pop) & ~bus.fifo_clr;
      ovr_set  = push_req & full_q & ~do_pop & ~bus.fifo_clr;

      if (bus.fifo_clr) begin
         wr_next = '0;
         rd_next = '0;
      end else begin
         wr_next = wr_ptr + {{AW{1'b0}}, do_push};
         rd_next = rd_ptr + {{AW{1'b0}}, do_pop};
      end
      count_next = wr_next - rd_next;
   end

   always_comb begin
      trig_level = 32'd1;
      case (bus.trig_lvl)
         2'b00:   trig_level = 32'd1;
         2'b01:   trig_level = 32'd4;
         2'b10:   trig_level = 32'd8;
         default: trig_level = 32'(DEPTH - 2);
      endcase
   end

   always_ff @(posedge baud_clk) begin
      if (reset) begin
         done_q    <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         empty_q   <= 1'b1;
         full_q    <= 1'b0;
         rd_data_q <= '0;
         rd_pe_q   <= 1'b0;
         rd_fe_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         done_q  <= bus.rx_done_i;
         wr_ptr  <= wr_next;
         rd_ptr  <= rd_next;
         count_q <= count_next;
         empty_q <= (count_next == '0);
         full_q  <= (count_next == (AW+1)'(DEPTH));
         if (do_pop) begin
            {rd_fe_q, rd_pe_q, rd_data_q} <= mem[rd_ptr[AW-1:0]];
         end
         if (ovr_set) begin
            overrun_q <= 1'b1;
         end else if (bus.ovr_clr) begin
            overrun_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge baud_clk) begin
      if (!reset && do_push) begin
         mem[wr_ptr[AW-1:0]] <= entry;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_pe    = rd_pe_q;
   assign bus.rd_fe    = rd_fe_q;
   assign bus.empty    = empty_q;
   assign bus.full     = full_q;
   assign bus.count    = count_q;
   assign bus.overrun  = overrun_q;
   assign bus.trig_int = (32'(count_q) >= trig_level);

endmodule
